// File: rtl/switch_debouncer_pkg.sv
// Shared timing constants and types for the switch debouncer and the clock divider.
package switch_debouncer_pkg;

    localparam int unsigned CLK_FREQ_HZ             = 100_000_000;
    localparam int unsigned DEBOUNCE_MS             = 10;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;
    localparam int unsigned CNT_W_DEFAULT           = 20;

    // STABLE: synchronised input matches the accepted level; COUNTING: it differs.
    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } deb_state_e;

    // True when a counter of cnt_w bits can reach cycles-1 without wrapping.
    function automatic bit cnt_fits(input int unsigned cnt_w, input int unsigned cycles);
        return (64'd1 << cnt_w) >= 64'(cycles);
    endfunction

endpackage

// File: rtl/switch_debouncer_channel.sv
// One debounced input bit: 2-flop synchroniser, qualification counter, level and edge strobes.
module switch_debouncer_channel
    import switch_debouncer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 8,
    parameter int unsigned CNT_W           = 4
) (
    input  logic clk,
    input  logic i_rst,
    input  logic i_sw,
    output logic o_sw,
    output logic o_rise,
    output logic o_fall,
    output logic o_edge_c
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_s1;
    logic             r_s0;
    deb_state_e       r_state;
    deb_state_e       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_sw;
    logic             r_rise;
    logic             r_fall;
    logic             w_diff;
    logic             w_accept;
    logic             w_sw_next;
    logic             w_rise_next;
    logic             w_fall_next;

    // Two-stage synchroniser for the asynchronous raw input.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1 <= 1'b0;
            r_s0 <= 1'b0;
        end else begin
            r_s1 <= i_sw;
            r_s0 <= r_s1;
        end
    end

    assign w_diff   = r_s0 ^ r_sw;
    assign w_accept = (r_state == ST_COUNTING) && w_diff && (r_cnt == LAST_CNT);

    // State register.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_STABLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: enter COUNTING on a difference, leave on reversal or acceptance.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_STABLE:   if (w_diff) w_next_state = ST_COUNTING;
            ST_COUNTING: if (!w_diff || w_accept) w_next_state = ST_STABLE;
            default:     w_next_state = ST_STABLE;
        endcase
    end

    // Next counter, level and strobe values; the counter is cleared on acceptance so it never wraps.
    always_comb begin
        w_cnt_next  = '0;
        w_sw_next   = r_sw;
        w_rise_next = 1'b0;
        w_fall_next = 1'b0;
        case (r_state)
            ST_STABLE: begin
                if (w_diff) w_cnt_next = CNT_W'(1);
            end
            ST_COUNTING: begin
                if (w_accept) begin
                    w_sw_next   = r_s0;
                    w_rise_next = r_s0;
                    w_fall_next = ~r_s0;
                end else if (w_diff) begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Counter, accepted level and one-cycle strobes.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_sw   <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_sw   <= w_sw_next;
            r_rise <= w_rise_next;
            r_fall <= w_fall_next;
        end
    end

    assign o_sw     = r_sw;
    assign o_rise   = r_rise;
    assign o_fall   = r_fall;
    assign o_edge_c = w_accept;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces NUM_SW asynchronous switch inputs; adds a registered any-edge pulse across channels.
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int unsigned NUM_SW          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_SW-1:0] sw_in,
    output logic [NUM_SW-1:0] sw_out,
    output logic [NUM_SW-1:0] rise,
    output logic [NUM_SW-1:0] fall,
    output logic              any_edge
);

    if (!cnt_fits(CNT_W, DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
        $fatal(1, "switch_debouncer: CNT_W too narrow for DEBOUNCE_CYCLES");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
        $fatal(1, "switch_debouncer: DEBOUNCE_CYCLES must be at least 2");
    end
    if (NUM_SW < 1) begin : g_bad_num_sw
        $fatal(1, "switch_debouncer: NUM_SW must be at least 1");
    end

    logic [NUM_SW-1:0] w_sw;
    logic [NUM_SW-1:0] w_rise;
    logic [NUM_SW-1:0] w_fall;
    logic [NUM_SW-1:0] w_edge;
    logic              r_any_edge;

    for (genvar g = 0; g < NUM_SW; g++) begin : g_ch
        switch_debouncer_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk      (clk),
            .i_rst    (reset),
            .i_sw     (sw_in[g]),
            .o_sw     (w_sw[g]),
            .o_rise   (w_rise[g]),
            .o_fall   (w_fall[g]),
            .o_edge_c (w_edge[g])
        );
    end

    // any_edge is registered from the same acceptance terms that load rise/fall, so it lines up with them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_any_edge <= 1'b0;
        end else begin
            r_any_edge <= |w_edge;
        end
    end

    assign sw_out   = w_sw;
    assign rise     = w_rise;
    assign fall     = w_fall;
    assign any_edge = r_any_edge;

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer with a window-based reference model.
module tb_switch_debouncer;

    localparam int unsigned NSW = 4;
    localparam int unsigned DC  = 8;
    localparam int unsigned CW  = 4;
    localparam int unsigned HL  = DC + 2;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [NSW-1:0] sw_in = '0;
    logic [NSW-1:0] sw_out;
    logic [NSW-1:0] rise;
    logic [NSW-1:0] fall;
    logic           any_edge;

    int n_cmp = 0;
    int n_err = 0;

    // Model: history of sampled inputs (index 0 = this edge). The synchronised value seen
    // at an edge is the sample from two edges earlier; a channel flips when the last DC
    // synchronised values all equal the opposite of its accepted level.
    logic [NSW-1:0] hist [$];
    logic [NSW-1:0] exp_out;
    logic [NSW-1:0] exp_rise;
    logic [NSW-1:0] exp_fall;
    logic           exp_any;

    switch_debouncer #(
        .NUM_SW          (NSW),
        .DEBOUNCE_CYCLES (DC),
        .CNT_W           (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sw_in    (sw_in),
        .sw_out   (sw_out),
        .rise     (rise),
        .fall     (fall),
        .any_edge (any_edge)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] obs();
        return {sw_out, rise, fall, any_edge};
    endfunction

    function automatic logic [12:0] expv();
        return {exp_out, exp_rise, exp_fall, exp_any};
    endfunction

    task automatic model_clear();
        hist.delete();
        repeat (HL) hist.push_front('0);
        exp_out  = '0;
        exp_rise = '0;
        exp_fall = '0;
        exp_any  = 1'b0;
    endtask

    task automatic model_edge();
        logic [NSW-1:0] smp;
        logic           all_new;
        hist.push_front(reset ? '0 : sw_in);
        if (hist.size() > HL) void'(hist.pop_back());
        exp_rise = '0;
        exp_fall = '0;
        if (!reset) begin
            for (int i = 0; i < int'(NSW); i++) begin
                all_new = 1'b1;
                for (int k = 2; k < int'(HL); k++) begin
                    smp = hist[k];
                    if (smp[i] == exp_out[i]) all_new = 1'b0;
                end
                if (all_new) begin
                    exp_out[i]  = ~exp_out[i];
                    exp_rise[i] = exp_out[i];
                    exp_fall[i] = ~exp_out[i];
                end
            end
        end
        exp_any = |(exp_rise | exp_fall);
    endtask

    task automatic step(input logic [NSW-1:0] v);
        sw_in = v;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        model_clear();
        #1;
        n_cmp++;
        if (obs() !== 13'b0) begin
            n_err++;
            $display("FAIL reset_async got %b want %b", obs(), 13'b0);
        end
        for (int t = 0; t < 3; t++) begin
            step(4'b1010);
            n_cmp++;
            if (obs() !== expv()) begin
                n_err++;
                $display("FAIL reset_hold t=%0d got %b want %b", t, obs(), expv());
            end
        end
        sw_in = '0;
        #2 reset = 1'b0;
    endtask

    task automatic test_clean_step();
        int first = -1;
        int pulses = 0;
        for (int t = 0; t < 20; t++) begin
            step(4'b0001);
            n_cmp++;
            if (obs() !== expv()) begin
                n_err++;
                $display("FAIL clean_step t=%0d got %b want %b", t, obs(), expv());
            end
            if (rise[0] && first < 0) first = t;
            pulses += int'(rise[0]);
        end
        // Step index 9 is the 10th rising edge after the input changed.
        n_cmp++;
        if (first != 9 || pulses != 1) begin
            n_err++;
            $display("FAIL clean_step_latency got idx=%0d pulses=%0d want idx=9 pulses=1", first, pulses);
        end
    endtask

    task automatic test_bounce();
        logic [NSW-1:0] v;
        int first = -1;
        int bad = 0;
        for (int t = 0; t < 24 + 15; t++) begin
            v = 4'b0001;
            v[1] = (t >= 24) ? 1'b1 : ((t / 3) % 2 == 0);
            step(v);
            n_cmp++;
            if (obs() !== expv()) begin
                n_err++;
                $display("FAIL bounce t=%0d got %b want %b", t, obs(), expv());
            end
            if (t < 24 + 9 && (rise[1] || fall[1] || sw_out[1])) bad++;
            if (rise[1] && first < 0) first = t;
        end
        n_cmp++;
        if (bad != 0 || first != 24 + 9) begin
            n_err++;
            $display("FAIL bounce_accept got bad=%0d idx=%0d want bad=0 idx=%0d", bad, first, 24 + 9);
        end
    endtask

    task automatic test_glitch();
        int bad = 0;
        for (int t = 0; t < 12; t++) begin
            step(4'b0111);
            n_cmp++;
            if (obs() !== expv()) begin
                n_err++;
                $display("FAIL glitch_setup t=%0d got %b want %b", t, obs(), expv());
            end
        end
        // Two back-to-back 7-cycle drops: the second only survives if the counter was cleared.
        for (int rep = 0; rep < 2; rep++) begin
            for (int t = 0; t < 7 + 12; t++) begin
                step(t < 7 ? 4'b0011 : 4'b0111);
                n_cmp++;
                if (obs() !== expv()) begin
                    n_err++;
                    $display("FAIL glitch rep=%0d t=%0d got %b want %b", rep, t, obs(), expv());
                end
                if (fall[2] || !sw_out[2]) bad++;
            end
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL glitch_reject got bad_cycles=%0d want 0", bad);
        end
    endtask

    task automatic test_simultaneous();
        int pulses;
        for (int t = 0; t < 12; t++) begin
            step(4'b0000);
            n_cmp++;
            if (obs() !== expv()) begin
                n_err++;
                $display("FAIL simul_clear t=%0d got %b want %b", t, obs(), expv());
            end
        end
        for (int dir = 0; dir < 2; dir++) begin
            pulses = 0;
            for (int t = 0; t < 14; t++) begin
                step(dir == 0 ? 4'b1011 : 4'b0000);
                n_cmp++;
                if (obs() !== expv()) begin
                    n_err++;
                    $display("FAIL simul dir=%0d t=%0d got %b want %b", dir, t, obs(), expv());
                end
                pulses += int'(any_edge);
                if (t == 9) begin
                    n_cmp++;
                    if (dir == 0 && {sw_out, rise, fall} !== {4'b1011, 4'b1011, 4'b0000}) begin
                        n_err++;
                        $display("FAIL simul_rise got out=%b rise=%b fall=%b want out=1011 rise=1011 fall=0000", sw_out, rise, fall);
                    end
                    if (dir == 1 && {sw_out, rise, fall} !== {4'b0000, 4'b0000, 4'b1011}) begin
                        n_err++;
                        $display("FAIL simul_fall got out=%b rise=%b fall=%b want out=0000 rise=0000 fall=1011", sw_out, rise, fall);
                    end
                end
            end
            n_cmp++;
            if (pulses != 1) begin
                n_err++;
                $display("FAIL simul_any_edge dir=%0d got pulses=%0d want 1", dir, pulses);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        int first = -1;
        for (int t = 0; t < 12; t++) begin
            step(4'b0100);
            n_cmp++;
            if (obs() !== expv()) begin
                n_err++;
                $display("FAIL midrst_setup t=%0d got %b want %b", t, obs(), expv());
            end
        end
        // Seven edges after the change the channel-0 counter holds 5.
        for (int t = 0; t < 7; t++) begin
            step(4'b0101);
            n_cmp++;
            if (obs() !== expv()) begin
                n_err++;
                $display("FAIL midrst_count t=%0d got %b want %b", t, obs(), expv());
            end
        end
        #1 reset = 1'b1;
        model_clear();
        #1;
        n_cmp++;
        if (obs() !== 13'b0) begin
            n_err++;
            $display("FAIL midrst_async got %b want %b", obs(), 13'b0);
        end
        for (int t = 0; t < 3; t++) begin
            step(4'b0101);
            n_cmp++;
            if (obs() !== expv()) begin
                n_err++;
                $display("FAIL midrst_hold t=%0d got %b want %b", t, obs(), expv());
            end
        end
        #2 reset = 1'b0;
        for (int t = 0; t < 14; t++) begin
            step(4'b0101);
            n_cmp++;
            if (obs() !== expv()) begin
                n_err++;
                $display("FAIL midrst_after t=%0d got %b want %b", t, obs(), expv());
            end
            if (rise[0] && first < 0) first = t;
            if (t == 9) begin
                n_cmp++;
                if (rise !== 4'b0101) begin
                    n_err++;
                    $display("FAIL midrst_rise got rise=%b want 0101", rise);
                end
            end
        end
        n_cmp++;
        if (first != 9) begin
            n_err++;
            $display("FAIL midrst_latency got idx=%0d want 9", first);
        end
    endtask

    task automatic test_power_up();
        sw_in = 4'b1111;
        #1 reset = 1'b1;
        model_clear();
        #1;
        n_cmp++;
        if (obs() !== 13'b0) begin
            n_err++;
            $display("FAIL powerup_async got %b want %b", obs(), 13'b0);
        end
        for (int t = 0; t < 5; t++) begin
            step(4'b1111);
            n_cmp++;
            if (obs() !== 13'b0) begin
                n_err++;
                $display("FAIL powerup_hold t=%0d got %b want %b", t, obs(), 13'b0);
            end
        end
        #2 reset = 1'b0;
        for (int t = 0; t < 14; t++) begin
            step(4'b1111);
            n_cmp++;
            if (obs() !== expv()) begin
                n_err++;
                $display("FAIL powerup t=%0d got %b want %b", t, obs(), expv());
            end
            if (t == 9) begin
                n_cmp++;
                if ({sw_out, rise, any_edge} !== {4'b1111, 4'b1111, 1'b1}) begin
                    n_err++;
                    $display("FAIL powerup_rise got out=%b rise=%b any=%b want 1111 1111 1", sw_out, rise, any_edge);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [NSW-1:0] cur = sw_in;
        for (int t = 0; t < 1500; t++) begin
            for (int i = 0; i < int'(NSW); i++) begin
                if ($urandom_range(0, 11) == 0) cur[i] = ~cur[i];
            end
            step(cur);
            n_cmp++;
            if (obs() !== expv()) begin
                n_err++;
                $display("FAIL random t=%0d in=%b got %b want %b", t, cur, obs(), expv());
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_clean_step();
        test_bounce();
        test_glitch();
        test_simultaneous();
        test_reset_mid_count();
        test_power_up();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got no completion want finish before 500000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
Upstream conditioning stage for the slide-switch and push-button inputs that drive the shift/flash LED datapath (shift_sel, func_sel and future mode controls).
- Synchronises each raw asynchronous input to clk.
- Rejects mechanical bounce.
- Presents clean levels plus single-cycle rise/fall strobes.
- Runs entirely on the 100 MHz master clock, ahead of any clock divider.

Parameters:
NUM_SW, 4, number of independent input channels (>=1).
DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised cycles required to accept a new level (10 ms at 100 MHz); must be >=2.
CNT_W, 20, per-channel counter width; must satisfy 2**CNT_W >= DEBOUNCE_CYCLES (elaboration-time check, fatal if violated).

Ports:
clk  input  1  master clock, 100 MHz, all logic on rising edge.
reset  input  1  asynchronous, active-high reset.
sw_in  input  NUM_SW  raw switch/button levels, asynchronous to clk.
sw_out  output  NUM_SW  debounced stable levels.
rise  output  NUM_SW  one-cycle strobe per channel when sw_out goes 0->1.
fall  output  NUM_SW  one-cycle strobe per channel when sw_out goes 1->0.
any_edge  output  1  OR of all rise and fall bits, registered in the same cycle as those bits.

Behaviour:
- Reset (asserted, asynchronous):
  - Synchroniser flops, counters, sw_out, rise, fall and any_edge all go to 0 immediately.
  - They hold 0 while reset is high.
- Synchroniser: two flops per bit, s1 <= sw_in; s0 <= s1. No logic between the two stages.
- Per-channel FSM, two states:
  - STABLE: s0 == sw_out. Counter holds 0.
  - COUNTING: s0 != sw_out. Counter increments by 1 each cycle.
- Transitions:
  - STABLE -> COUNTING on the first cycle s0 differs from sw_out; counter becomes 1 on that edge.
  - COUNTING -> STABLE with counter cleared if s0 returns to sw_out before acceptance. No output change, no strobe.
  - Acceptance: in COUNTING, when counter == DEBOUNCE_CYCLES-1 and s0 still differs, then on that edge:
    - sw_out <= s0;
    - rise or fall <= 1 according to direction;
    - counter <= 0;
    - state -> STABLE.
- Strobes are registered and high for exactly one cycle, coincident with the first cycle of the new sw_out value. rise[i] and fall[i] are never both high.
- Latency: a clean step on sw_in[i] appears on sw_out[i] exactly DEBOUNCE_CYCLES+2 rising edges later: 2 synchroniser edges plus DEBOUNCE_CYCLES counting edges.
- Bounce: any reversal of s0 during COUNTING restarts qualification from zero. Accepted level is the level stable for the final DEBOUNCE_CYCLES cycles.
- Counter never wraps: it is cleared at acceptance and its maximum value is DEBOUNCE_CYCLES-1.
- Channels are fully independent. Simultaneous acceptances on several channels produce simultaneous strobes; any_edge is a single 1-cycle pulse.
- Reset mid-count:
  - Qualification is aborted and the counter is cleared.
  - After release, an input held high qualifies from scratch: rise after DEBOUNCE_CYCLES+2 edges.
  - This power-up rise is intentional and downstream must tolerate it.
- No combinational path from sw_in to any output.

Decomposition:
- Shared constants file/package:
  - CLK_FREQ_HZ = 100_000_000.
  - DEBOUNCE_MS = 10.
  - Derived DEBOUNCE_CYCLES default.
  - These are also used by the clock divider.
- One natural sub-module: debounce_channel, holding the 2-flop synchroniser, counter, FSM and rise/fall registers for one bit. It is instantiated NUM_SW times via generate.
- Top level adds only the any_edge OR register.

Test Plan:
All scenarios use NUM_SW=4, DEBOUNCE_CYCLES=8, CNT_W=4.

1. Clean step: sw_in[0] 0->1 at cycle 0, held. Required: sw_out[0]=1 first at cycle 10; rise[0]=1 for cycle 10 only; any_edge=1 cycle 10; other channels stay 0.
2. Bounce: sw_in[1] toggles every 3 cycles for 24 cycles, then settles 1. Required: no strobe and sw_out[1]=0 throughout; rise[1] exactly 10 cycles after the final edge.
3. Glitch rejection: sw_out[2]=1 stable; sw_in[2] drops to 0 for 7 cycles, then returns to 1. Required: no fall[2], sw_out[2] stays 1, counter back to 0.
4. Simultaneous: sw_in[3:0] 0000->1011 at the same cycle. Required: sw_out=1011 and rise=1011 on the same cycle, any_edge one pulse. Then 1011->0000 gives fall=1011 on one cycle.
5. Reset mid-count: sw_in[0]=1, reset asserted when counter=5 and released 3 cycles later. Required: all outputs 0 immediately (asynchronous); rise[0] exactly 10 cycles after release.
6. Power-up high: sw_in=1111 during reset. Required: outputs 0 during reset; sw_out=1111 and rise=1111 exactly 10 cycles after reset deasserts.
